// File: rtl/dmem_responder.sv
// Slave end of the dmem_* bus: one access at a time on an internal word RAM,
// with programmable wait states and a single-cycle ack/err/misaligned response.
module dmem_responder #(
  parameter int unsigned     XLEN    = 32,
  parameter logic [XLEN-1:0] BASE    = '0,
  parameter int unsigned     DEPTH   = 1024,
  parameter int unsigned     LATENCY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic            dmem_we,
  input  logic [2:0]      dmem_size,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            stall_inject,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_ack,
  output logic            dmem_err,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault,
  output logic [15:0]     rd_cnt,
  output logic [15:0]     wr_cnt,
  output logic [15:0]     fault_cnt
);

  localparam int unsigned Aw      = $clog2(DEPTH);
  localparam logic [3:0]  LatInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [2:0]  SzByte  = 3'd0;
  localparam logic [2:0]  SzHword = 3'd1;
  localparam logic [2:0]  SzWord  = 3'd2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q;
  logic [XLEN-1:0] adr_q, d_q;
  logic            we_q;
  logic [2:0]      size_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic            go_resp;
  logic [XLEN-1:0] src_adr, src_d, offset;
  logic            src_we;
  logic [2:0]      src_size;
  logic            is_mis, is_err, is_ok;
  logic [Aw-1:0]   idx;
  logic [3:0]      be;
  logic            unused_bits;

  assign dmem_page_fault = 1'b0;

  always_comb begin
    state_d = state_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dmem_req) begin
          state_d = (LATENCY > 0) ? StWait : StResp;
          go_resp = (LATENCY == 0);
        end
      end
      StWait: begin
        if (!stall_inject && cnt_q == 4'd0) begin
          state_d = StResp;
          go_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero latency the response is decided on the capture edge itself, so
  // classify straight from the bus in IDLE and from the captured copy otherwise.
  always_comb begin
    src_adr  = (state_q == StIdle) ? dmem_adr  : adr_q;
    src_d    = (state_q == StIdle) ? dmem_d    : d_q;
    src_we   = (state_q == StIdle) ? dmem_we   : we_q;
    src_size = (state_q == StIdle) ? dmem_size : size_q;

    offset = src_adr - BASE;
    idx    = offset[Aw+1:2];
    is_mis = ((src_size == SzHword) && src_adr[0]) ||
             ((src_size == SzWord) && (src_adr[1:0] != 2'b00));
    is_err = !is_mis && ((src_size > SzWord) || (src_adr < BASE) ||
                         (|offset[XLEN-1:Aw+2]));
    is_ok  = !is_mis && !is_err;

    be = 4'b0000;
    case (src_size)
      SzByte:  be = 4'b0001 << src_adr[1:0];
      SzHword: be = 4'b0011 << src_adr[1:0];
      SzWord:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign unused_bits = ^offset[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      adr_q           <= '0;
      d_q             <= '0;
      we_q            <= 1'b0;
      size_q          <= '0;
      dmem_q          <= '0;
      dmem_ack        <= 1'b0;
      dmem_err        <= 1'b0;
      dmem_misaligned <= 1'b0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      fault_cnt       <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == StIdle && dmem_req) begin
        adr_q  <= dmem_adr;
        d_q    <= dmem_d;
        we_q   <= dmem_we;
        size_q <= dmem_size;
        cnt_q  <= LatInit;
      end else if (state_q == StWait && !stall_inject && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (go_resp) begin
        dmem_ack        <= is_ok;
        dmem_err        <= is_err;
        dmem_misaligned <= is_mis;
        dmem_q          <= (is_ok && !src_we) ? mem[idx] : '0;
      end

      if (state_q == StResp) begin
        dmem_ack        <= 1'b0;
        dmem_err        <= 1'b0;
        dmem_misaligned <= 1'b0;
        dmem_q          <= '0;
        if (dmem_ack && !we_q && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
        if (dmem_ack && we_q && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        if ((dmem_err || dmem_misaligned) && fault_cnt != 16'hFFFF) begin
          fault_cnt <= fault_cnt + 16'd1;
        end
      end
    end
  end

  // RAM is not reset; a reset on the response edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && go_resp && is_ok && src_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= src_d[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 0/3/5) behind a
// shared bus, expected responses queued at drive time and popped on response.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  size;
  logic [31:0] adr;
  logic [31:0] d;
  logic        stall;
  int          sel;

  logic [2:0]  reqs;
  logic [31:0] q    [3];
  logic        ack  [3];
  logic        err  [3];
  logic        mis  [3];
  logic        pf   [3];
  logic [15:0] rdc  [3];
  logic [15:0] wrc  [3];
  logic [15:0] ftc  [3];

  logic [31:0] o_q;
  logic        o_ack, o_err, o_mis, o_pf;
  logic [15:0] o_rd, o_wr, o_ft;

  typedef struct {
    logic [2:0]  flags;  // {misaligned, err, ack}
    logic [31:0] q;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assign reqs = {req && sel == 2, req && sel == 1, req && sel == 0};

  always_comb begin
    o_q   = q[sel];
    o_ack = ack[sel];
    o_err = err[sel];
    o_mis = mis[sel];
    o_pf  = pf[sel];
    o_rd  = rdc[sel];
    o_wr  = wrc[sel];
    o_ft  = ftc[sel];
  end

  dmem_responder #(.XLEN(32), .BASE(32'h0), .DEPTH(1024), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .dmem_req(reqs[0]), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .stall_inject(stall), .dmem_q(q[0]),
    .dmem_ack(ack[0]), .dmem_err(err[0]), .dmem_misaligned(mis[0]),
    .dmem_page_fault(pf[0]), .rd_cnt(rdc[0]), .wr_cnt(wrc[0]), .fault_cnt(ftc[0])
  );

  dmem_responder #(.XLEN(32), .BASE(32'h0), .DEPTH(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .dmem_req(reqs[1]), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .stall_inject(stall), .dmem_q(q[1]),
    .dmem_ack(ack[1]), .dmem_err(err[1]), .dmem_misaligned(mis[1]),
    .dmem_page_fault(pf[1]), .rd_cnt(rdc[1]), .wr_cnt(wrc[1]), .fault_cnt(ftc[1])
  );

  dmem_responder #(.XLEN(32), .BASE(32'h0), .DEPTH(1024), .LATENCY(5)) u_l5 (
    .clk(clk), .rst(rst), .dmem_req(reqs[2]), .dmem_adr(adr), .dmem_we(we),
    .dmem_size(size), .dmem_d(d), .stall_inject(stall), .dmem_q(q[2]),
    .dmem_ack(ack[2]), .dmem_err(err[2]), .dmem_misaligned(mis[2]),
    .dmem_page_fault(pf[2]), .rd_cnt(rdc[2]), .wr_cnt(wrc[2]), .fault_cnt(ftc[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access, scramble the bus after capture, wait for the response.
  task automatic access(input string tag, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] eflags, input logic [31:0] eq,
                        input int elat, input int stalls);
    exp_t e;
    int   n;
    logic got;
    e.flags = eflags;
    e.q     = eq;
    e.lat   = elat;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b1; we = w; size = sz; adr = a; d = wd; stall = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      adr   = ~a;
      d     = ~wd;
      we    = ~w;
      size  = sz ^ 3'd1;
      stall = (n <= stalls);
      if (o_ack || o_err || o_mis) got = 1'b1;
    end
    req   = 1'b0;
    stall = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      total++;
      bad++;
      $error("FAIL %s_timeout observed=no_response expected=lat_%0d", tag, e.lat);
    end else begin
      chk({tag, "_flags"}, {29'd0, o_mis, o_err, o_ack}, {29'd0, e.flags});
      chk({tag, "_q"}, o_q, e.q);
      chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    end
    @(posedge clk); #1;
    chk({tag, "_one_cycle"}, {29'd0, o_mis, o_err, o_ack}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 3'd0; adr = '0; d = '0; stall = 1'b0;
    sel = 0;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack", 32'(o_ack), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_mis", 32'(o_mis), 32'd0);
    chk("rst_pf", 32'(o_pf), 32'd0);
    chk("rst_q", o_q, 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_fault", 32'(o_ft), 32'd0);

    // LATENCY=0: word write/read.
    access("w_word", 1'b1, 3'd2, 32'h8, 32'hDEADBEEF, 3'b001, 32'h0, 1, 0);
    access("r_word", 1'b0, 3'd2, 32'h8, 32'h0, 3'b001, 32'hDEADBEEF, 1, 0);
    chk("cnt_wr1", 32'(o_wr), 32'd1);
    chk("cnt_rd1", 32'(o_rd), 32'd1);

    // Byte / halfword lanes.
    access("w_pre", 1'b1, 3'd2, 32'h10, 32'h0, 3'b001, 32'h0, 1, 0);
    access("w_byte", 1'b1, 3'd0, 32'h12, 32'h00AB0000, 3'b001, 32'h0, 1, 0);
    access("w_hword", 1'b1, 3'd1, 32'h10, 32'h00001234, 3'b001, 32'h0, 1, 0);
    access("r_lanes", 1'b0, 3'd2, 32'h10, 32'h0, 3'b001, 32'h00AB1234, 1, 0);

    // Faults.
    access("f_mis", 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 3'b100, 32'h0, 1, 0);
    access("r_after_mis", 1'b0, 3'd2, 32'h10, 32'h0, 3'b001, 32'h00AB1234, 1, 0);
    access("f_range", 1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF, 3'b010, 32'h0, 1, 0);
    access("f_size3", 1'b0, 3'd3, 32'h10, 32'h0, 3'b010, 32'h0, 1, 0);
    chk("cnt_fault3", 32'(o_ft), 32'd3);
    chk("cnt_wr4", 32'(o_wr), 32'd4);
    chk("cnt_rd3", 32'(o_rd), 32'd3);

    // LATENCY=3 with two stall cycles in WAIT.
    sel = 1;
    access("l3_w", 1'b1, 3'd2, 32'h8, 32'hCAFEF00D, 3'b001, 32'h0, 4, 0);
    access("l3_r_stall", 1'b0, 3'd2, 32'h8, 32'h0, 3'b001, 32'hCAFEF00D, 6, 2);

    // LATENCY=5: reset two cycles after a write capture abandons it.
    sel = 2;
    access("l5_w_old", 1'b1, 3'd2, 32'h20, 32'h11111111, 3'b001, 32'h0, 6, 0);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 3'd2; adr = 32'h20; d = 32'h22222222;
    @(posedge clk); #1;
    req  = 1'b0;
    seen = 1'b0;
    @(posedge clk); #1;
    seen = seen | o_ack | o_err | o_mis;
    rst  = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | o_ack | o_err | o_mis;
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | o_ack | o_err | o_mis;
    end
    chk("l5_no_resp", 32'(seen), 32'd0);
    chk("l5_rd0", 32'(o_rd), 32'd0);
    chk("l5_wr0", 32'(o_wr), 32'd0);
    chk("l5_fault0", 32'(o_ft), 32'd0);
    access("l5_r_old", 1'b0, 3'd2, 32'h20, 32'h0, 3'b001, 32'h11111111, 6, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
